// File: rtl/enemy_bullets_if.sv
// Shooter request handshake between the enemy shot pool (master) and the enemy formation (slave).
interface enemy_bullets_if #(
    parameter int NUM_COLS = 8
);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic                    shot_req;
    logic [COL_W-1:0]        shot_col;
    logic                    shooter_valid;
    logic                    shooter_none;
    logic signed [11:0]      shooter_x;
    logic signed [11:0]      shooter_y;

    modport master (
        output shot_req, shot_col,
        input  shooter_valid, shooter_none, shooter_x, shooter_y
    );

    modport slave (
        input  shot_req, shot_col,
        output shooter_valid, shooter_none, shooter_x, shooter_y
    );
endinterface

// File: rtl/enemy_bullets.sv
// Pool of downward enemy shots: per-frame move/hit sweep, shooter request handshake,
// and a combinational pixel layer for the video mixer.
module enemy_bullets #(
    parameter int          NUM_SLOTS     = 4,
    parameter int          NUM_COLS      = 8,
    parameter int          EB_SPEED      = 4,
    parameter int          EB_W          = 4,
    parameter int          EB_H          = 10,
    parameter int          FIRE_COOLDOWN = 30,
    parameter int          REQ_TIMEOUT   = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          VRES          = 720,
    parameter logic [23:0] EB_COLOR      = 24'hFF4040
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               enable,
    input  logic signed [11:0] player_left,
    input  logic signed [11:0] player_right,
    input  logic signed [11:0] player_top,
    input  logic signed [11:0] player_bottom,
    enemy_bullets_if.master    shot_bus,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    output logic [7:0]         pixel [0:2],
    output logic               player_hit,
    output logic [3:0]         live_count
);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 2);
    localparam int TO_W  = $clog2(REQ_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_SLOT     = IDX_W'(NUM_SLOTS - 1);
    localparam logic [CD_W-1:0]  COOLDOWN_INIT = CD_W'(FIRE_COOLDOWN);
    localparam logic [TO_W-1:0]  TIMEOUT_LAST  = TO_W'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN, REQ} state_t;

    state_t             state;
    logic [NUM_SLOTS-1:0] live;
    logic signed [11:0] slot_x [NUM_SLOTS];
    logic signed [11:0] slot_y [NUM_SLOTS];
    logic [IDX_W-1:0]   slot_idx;
    logic [CD_W-1:0]    cooldown;
    logic [TO_W-1:0]    wait_cnt;
    logic [15:0]        lfsr;
    logic               hit_flag;

    logic signed [13:0] y_next;
    logic signed [13:0] box_left;
    logic signed [13:0] box_right;
    logic signed [13:0] box_bottom;
    logic               leaves;
    logic               hits;
    logic               slot_hit;
    logic               any_free;
    logic [IDX_W-1:0]   free_idx;
    logic               draw;

    // Widened signed arithmetic so a shot near the bottom edge can never wrap back on screen.
    always_comb begin
        y_next     = 14'(slot_y[slot_idx]) + 14'(EB_SPEED);
        box_left   = 14'(slot_x[slot_idx]) - 14'(EB_W / 2);
        box_right  = 14'(slot_x[slot_idx]) + 14'(EB_W / 2);
        box_bottom = y_next + 14'(EB_H);
        leaves     = (y_next >= 14'(VRES));
        hits       = (box_left <= 14'(player_right)) && (box_right >= 14'(player_left)) &&
                     (y_next <= 14'(player_bottom)) && (box_bottom >= 14'(player_top));
        slot_hit   = live[slot_idx] && !leaves && hits;
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!live[k]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        draw = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (live[k] &&
                14'(hpos) >= 14'(slot_x[k]) - 14'(EB_W / 2) &&
                14'(hpos) <= 14'(slot_x[k]) + 14'(EB_W / 2) &&
                14'(vpos) >= 14'(slot_y[k]) &&
                14'(vpos) <= 14'(slot_y[k]) + 14'(EB_H))
                draw = 1'b1;
        end
        pixel[2] = draw ? EB_COLOR[23:16] : 8'h00;
        pixel[1] = draw ? EB_COLOR[15:8]  : 8'h00;
        pixel[0] = draw ? EB_COLOR[7:0]   : 8'h00;
    end

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge pixel_clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state             <= IDLE;
            live              <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_x[k] <= '0;
                slot_y[k] <= '0;
            end
            slot_idx          <= '0;
            cooldown          <= COOLDOWN_INIT;
            wait_cnt          <= '0;
            hit_flag          <= 1'b0;
            shot_bus.shot_req <= 1'b0;
            shot_bus.shot_col <= '0;
            player_hit        <= 1'b0;
            live_count        <= '0;
        end else begin
            player_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (fsync) begin
                        state    <= MOVE;
                        slot_idx <= '0;
                        hit_flag <= 1'b0;
                    end
                end
                MOVE: begin
                    if (live[slot_idx]) begin
                        if (leaves || hits) begin
                            live[slot_idx] <= 1'b0;
                            live_count     <= live_count - 4'd1;
                        end else begin
                            slot_y[slot_idx] <= y_next[11:0];
                        end
                    end
                    // The last slot's hit is folded straight into the pulse shown during SPAWN.
                    if (slot_idx == LAST_SLOT) begin
                        state      <= SPAWN;
                        player_hit <= hit_flag | slot_hit;
                    end else begin
                        slot_idx <= slot_idx + 1'b1;
                        hit_flag <= hit_flag | slot_hit;
                    end
                end
                SPAWN: begin
                    if (cooldown != '0) begin
                        cooldown <= cooldown - 1'b1;
                        state    <= IDLE;
                    end else if (enable && any_free) begin
                        shot_bus.shot_col <= lfsr[COL_W-1:0];
                        shot_bus.shot_req <= 1'b1;
                        wait_cnt          <= '0;
                        state             <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (shot_bus.shooter_valid) begin
                        shot_bus.shot_req <= 1'b0;
                        state             <= IDLE;
                        if (!shot_bus.shooter_none) begin
                            live[free_idx]   <= 1'b1;
                            slot_x[free_idx] <= shot_bus.shooter_x;
                            slot_y[free_idx] <= shot_bus.shooter_y;
                            live_count       <= live_count + 4'd1;
                            cooldown         <= COOLDOWN_INIT;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        shot_bus.shot_req <= 1'b0;
                        state             <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enemy_bullets.sv
// Frame-level bench for enemy_bullets: a formation responder plus a per-frame model of
// shot motion, hits, cooldown and spawning, with directed scenarios then random frames.
module tb_enemy_bullets;
    localparam int          NUM_SLOTS     = 4;
    localparam int          NUM_COLS      = 8;
    localparam int          EB_SPEED      = 4;
    localparam int          EB_W          = 4;
    localparam int          EB_H          = 10;
    localparam int          FIRE_COOLDOWN = 1;
    localparam int          REQ_TIMEOUT   = 16;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam int          VRES          = 720;
    localparam logic [23:0] EB_COLOR      = 24'hFF4040;
    localparam int          FRAME_CYCLES  = 40;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic               fsync = 1'b0;
    logic               enable = 1'b0;
    logic signed [11:0] player_left = '0;
    logic signed [11:0] player_right = '0;
    logic signed [11:0] player_top = '0;
    logic signed [11:0] player_bottom = '0;
    logic signed [11:0] hpos = '0;
    logic signed [11:0] vpos = '0;
    logic [7:0]         pixel [0:2];
    logic               player_hit;
    logic [3:0]         live_count;

    enemy_bullets_if #(.NUM_COLS(NUM_COLS)) shot_bus ();

    enemy_bullets #(
        .NUM_SLOTS(NUM_SLOTS), .NUM_COLS(NUM_COLS), .EB_SPEED(EB_SPEED), .EB_W(EB_W),
        .EB_H(EB_H), .FIRE_COOLDOWN(FIRE_COOLDOWN), .REQ_TIMEOUT(REQ_TIMEOUT),
        .LFSR_SEED(LFSR_SEED), .VRES(VRES), .EB_COLOR(EB_COLOR)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .enable(enable),
        .player_left(player_left), .player_right(player_right),
        .player_top(player_top), .player_bottom(player_bottom),
        .shot_bus(shot_bus), .hpos(hpos), .vpos(vpos),
        .pixel(pixel), .player_hit(player_hit), .live_count(live_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Clock edges since reset release, so the expected shooter column is the LFSR sequence value.
    int cyc = 0;
    always @(posedge pixel_clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int tests_run = 0;
    int fails = 0;

    bit m_live [NUM_SLOTS];
    int m_x [NUM_SLOTS];
    int m_y [NUM_SLOTS];
    int m_cd;
    int pl, pr, pt, pb;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] lfsrAt(input int steps);
        logic [15:0] v;
        v = LFSR_SEED;
        for (int n = 0; n < steps; n++)
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    function automatic bit overlapsPlayer(input int x, input int y);
        return (x - EB_W / 2 <= pr) && (x + EB_W / 2 >= pl) && (y <= pb) && (y + EB_H >= pt);
    endfunction

    function automatic logic [31:0] pixModel(input int h, input int v);
        for (int k = 0; k < NUM_SLOTS; k++)
            if (m_live[k] && h >= m_x[k] - EB_W / 2 && h <= m_x[k] + EB_W / 2 &&
                v >= m_y[k] && v <= m_y[k] + EB_H)
                return {8'h00, EB_COLOR};
        return 32'h0;
    endfunction

    function automatic int liveCount();
        int n;
        n = 0;
        for (int k = 0; k < NUM_SLOTS; k++) if (m_live[k]) n++;
        return n;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NUM_SLOTS; k++) begin
            m_live[k] = 1'b0;
            m_x[k]    = 0;
            m_y[k]    = 0;
        end
        m_cd = FIRE_COOLDOWN;
    endtask

    task automatic setPlayer(input int l, input int r, input int t, input int b);
        @(negedge pixel_clk);
        pl = l; pr = r; pt = t; pb = b;
        player_left = 12'(l); player_right = 12'(r);
        player_top  = 12'(t); player_bottom = 12'(b);
    endtask

    task automatic checkPixel(input string tag, input int h, input int v);
        @(negedge pixel_clk);
        hpos = 12'(h);
        vpos = 12'(v);
        #1;
        checkOutput(tag, {8'h00, pixel[2], pixel[1], pixel[0]}, pixModel(h, v));
    endtask

    task automatic resetDut();
        @(negedge pixel_clk);
        rst = 1'b1;
        repeat (2) @(negedge pixel_clk);
        checkOutput("reset_req", shot_bus.shot_req, 0);
        checkOutput("reset_col", shot_bus.shot_col, 0);
        checkOutput("reset_live", live_count, 0);
        checkOutput("reset_hit", player_hit, 0);
        rst = 1'b0;
        modelReset();
    endtask

    // mode: 0 = shooter reply, 1 = empty column, 2 = no reply, 3 = reset while waiting
    task automatic applyStimulus(input bit en, input int mode, input int dly, input int sx, input int sy);
        bit          exp_req, exp_hit, req_seen;
        int          req_cycles, hits, yn, exp_len, dx, dy;
        logic [15:0] col_state;

        exp_hit = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (m_live[k]) begin
                yn = m_y[k] + EB_SPEED;
                if (yn >= VRES) m_live[k] = 1'b0;
                else if (overlapsPlayer(m_x[k], yn)) begin
                    m_live[k] = 1'b0;
                    exp_hit   = 1'b1;
                end else m_y[k] = yn;
            end
        end
        exp_req = 1'b0;
        if (m_cd != 0) m_cd--;
        else if (en && liveCount() < NUM_SLOTS) exp_req = 1'b1;

        @(negedge pixel_clk);
        enable = en;
        if ($urandom_range(0, 3) == 0) begin
            shot_bus.shooter_valid = 1'b1;
            shot_bus.shooter_none  = 1'b0;
            shot_bus.shooter_x     = 12'(sx);
            shot_bus.shooter_y     = 12'(sy);
            @(negedge pixel_clk);
            shot_bus.shooter_valid = 1'b0;
        end
        fsync = 1'b1;
        @(negedge pixel_clk);
        fsync = 1'b0;

        req_cycles = 0;
        hits       = 0;
        req_seen   = 1'b0;
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            shot_bus.shooter_valid = 1'b0;
            if (rst) begin
                checkOutput("rst_wait_req", shot_bus.shot_req, 0);
                checkOutput("rst_wait_live", live_count, 0);
                rst = 1'b0;
            end else begin
                if (player_hit) hits++;
                if (shot_bus.shot_req) begin
                    req_cycles++;
                    if (!req_seen) begin
                        req_seen  = 1'b1;
                        col_state = lfsrAt(cyc - 1);
                        checkOutput("shot_col", shot_bus.shot_col, col_state[2:0]);
                    end
                    if (mode == 3 && req_cycles == 1) rst = 1'b1;
                    else if (mode <= 1 && req_cycles == dly + 1) begin
                        shot_bus.shooter_valid = 1'b1;
                        shot_bus.shooter_none  = (mode == 1);
                        shot_bus.shooter_x     = 12'(sx);
                        shot_bus.shooter_y     = 12'(sy);
                    end
                end
            end
            @(negedge pixel_clk);
        end
        shot_bus.shooter_valid = 1'b0;

        checkOutput("req_seen", req_seen, exp_req);
        checkOutput("hit_pulses", hits, exp_hit);
        if (exp_req) begin
            exp_len = (mode == 2) ? REQ_TIMEOUT : (mode == 3) ? 1 : dly + 1;
            checkOutput("req_len", req_cycles, exp_len);
            if (mode == 0) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (!m_live[k]) begin
                        m_live[k] = 1'b1;
                        m_x[k]    = sx;
                        m_y[k]    = sy;
                        break;
                    end
                end
                m_cd = FIRE_COOLDOWN;
            end else if (mode == 3) modelReset();
        end
        checkOutput("live_count", live_count, liveCount());

        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (m_live[k]) begin
                dx = int'($urandom_range(0, EB_W)) - EB_W / 2;
                dy = int'($urandom_range(0, EB_H));
                checkPixel("px_inside", m_x[k] + dx, m_y[k] + dy);
                checkPixel("px_right_edge", m_x[k] + EB_W / 2 + 1, m_y[k]);
                checkPixel("px_below", m_x[k], m_y[k] + EB_H + 1);
            end
        end
        checkPixel("px_random", int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)));
    endtask

    initial begin
        int mode, r, sx, sy, w;
        shot_bus.shooter_valid = 1'b0;
        shot_bus.shooter_none  = 1'b0;
        shot_bus.shooter_x     = '0;
        shot_bus.shooter_y     = '0;
        modelReset();

        // Idle game: no requests, nothing drawn
        resetDut();
        setPlayer(1000, 1020, 690, 710);
        repeat (3) applyStimulus(1'b0, 2, 0, 0, 0);

        // First spawn and its drawn box
        applyStimulus(1'b1, 0, 0, 100, 50);
        checkPixel("t2_px_in", 100, 55);
        checkPixel("t2_px_out", 103, 55);

        // Motion and bottom exit
        resetDut();
        applyStimulus(1'b1, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 1, 200, 712);
        applyStimulus(1'b0, 2, 0, 0, 0);
        applyStimulus(1'b0, 2, 0, 0, 0);

        // Single hit, then two hits in one frame
        setPlayer(90, 110, 690, 710);
        resetDut();
        applyStimulus(1'b1, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 100, 678);
        applyStimulus(1'b0, 2, 0, 0, 0);
        applyStimulus(1'b1, 0, 2, 100, 670);
        applyStimulus(1'b1, 2, 0, 0, 0);
        applyStimulus(1'b1, 0, 3, 100, 678);
        applyStimulus(1'b0, 2, 0, 0, 0);

        // Empty column, timeout, then a normal reply
        setPlayer(1000, 1020, 690, 710);
        resetDut();
        applyStimulus(1'b1, 0, 0, 0, 0);
        applyStimulus(1'b1, 1, 2, 300, 100);
        applyStimulus(1'b1, 2, 0, 300, 100);
        applyStimulus(1'b1, 0, 4, 300, 100);

        // Full pool suppresses requests; reset during the handshake
        resetDut();
        applyStimulus(1'b1, 0, 0, 0, 0);
        for (int k = 0; k < NUM_SLOTS; k++) begin
            applyStimulus(1'b1, 0, k, 200 + 60 * k, 0);
            applyStimulus(1'b1, 2, 0, 0, 0);
        end
        applyStimulus(1'b1, 0, 0, 600, 20);
        resetDut();
        applyStimulus(1'b1, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 400, 10);
        applyStimulus(1'b1, 2, 0, 0, 0);
        applyStimulus(1'b1, 3, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 1, 500, 30);

        // Random frames
        for (int f = 0; f < 150; f++) begin
            if (f % 10 == 0) begin
                w = int'($urandom_range(10, 60));
                sx = int'($urandom_range(0, 1200));
                sy = int'($urandom_range(560, 680));
                setPlayer(sx, sx + w, sy, sy + int'($urandom_range(10, 30)));
            end
            r = int'($urandom_range(0, 19));
            mode = (r < 12) ? 0 : (r < 16) ? 1 : (r < 19) ? 2 : 3;
            if ($urandom_range(0, 1) == 0) begin
                sx = (pl + pr) / 2 + int'($urandom_range(0, 30)) - 15;
                sy = pt - int'($urandom_range(12, 80));
            end else begin
                sx = int'($urandom_range(0, 1279));
                sy = int'($urandom_range(0, 719));
            end
            applyStimulus($urandom_range(0, 9) != 0, mode, int'($urandom_range(0, 5)), sx, sy);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
